// File: rtl/bias_add_sat_stage_pkg.sv
// Shared lane constants for the bias path: lane width, saturation limits and a
// lane slice helper, also used by the bias constant blocks.
package bias_add_sat_stage_pkg;

  localparam int LANE_W  = 18;
  localparam int N_LANES = 16;

  localparam logic [LANE_W-1:0] SAT_MAX = 18'h1FFFF;
  localparam logic [LANE_W-1:0] SAT_MIN = 18'h20000;

  function automatic logic [LANE_W-1:0] laneSlice(input logic [N_LANES*LANE_W-1:0] bus,
                                                  input int unsigned k);
    return bus[k*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/bias_lane_sat.sv
// One lane of the bias stage: clamps a W+1 bit sum to W bits, then optional ReLU.
// Purely combinational; sat_o flags a clamp in either direction.
module bias_lane_sat
  import bias_add_sat_stage_pkg::*;
#(
  parameter int W = LANE_W
) (
  input  logic [W:0]   sum_i,
  input  logic         relu_en_i,
  output logic [W-1:0] res_o,
  output logic         sat_o
);

  logic [W-1:0] satVal;

  // The sum is out of W-bit range exactly when its top two bits disagree.
  always_comb begin
    satVal = sum_i[W-1:0];
    sat_o  = 1'b0;
    if (sum_i[W] != sum_i[W-1]) begin
      sat_o  = 1'b1;
      satVal = sum_i[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
    res_o = (relu_en_i && satVal[W-1]) ? '0 : satVal;
  end

endmodule

// File: rtl/bias_add_sat_stage.sv
// Bias add, saturate and ReLU stage between the conv adder tree and the
// activation buffer writer, as a two-register elastic valid/ready pipeline.
module bias_add_sat_stage
  import bias_add_sat_stage_pkg::*;
#(
  parameter int N_adder_tree = N_LANES,
  parameter int W            = LANE_W,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_adder_tree*W-1:0] bias_in,
  input  logic                    relu_en,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [N_adder_tree*W-1:0] s_data,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [N_adder_tree*W-1:0] m_data,
  output logic                    m_last,
  output logic                    frame_done,
  output logic [CNT_W-1:0]        sat_cnt
);

  localparam int N = N_adder_tree;

  logic                 v1_q, v1_d, v2_q, v2_d;
  logic [N*(W+1)-1:0]   sum1_q, sum1_d;
  logic                 last1_q, last1_d, relu1_q, relu1_d;
  logic [N*W-1:0]       data2_q, data2_d;
  logic                 last2_q, last2_d;
  logic                 frameDone_q, frameDone_d;
  logic [CNT_W-1:0]     satCnt_q, satCnt_d;

  logic [N*(W+1)-1:0]   sumNow;
  logic [N*W-1:0]       laneRes;
  logic [N-1:0]         laneSat;
  logic                 inFire, advance2, outFire;

  // Stage 1 adds in W+1 bits; stage 2 input is saturated from the registered sum.
  for (genvar k = 0; k < N; k++) begin : gLane
    assign sumNow[k*(W+1) +: W+1] = {s_data[k*W+W-1], s_data[k*W +: W]}
                                  + {bias_in[k*W+W-1], bias_in[k*W +: W]};

    bias_lane_sat #(.W(W)) uLane (
      .sum_i     (sum1_q[k*(W+1) +: W+1]),
      .relu_en_i (relu1_q),
      .res_o     (laneRes[k*W +: W]),
      .sat_o     (laneSat[k])
    );
  end

  assign s_ready  = !v1_q || !v2_q || m_ready;
  assign inFire   = s_valid && s_ready;
  assign advance2 = v1_q && (!v2_q || m_ready);
  assign outFire  = v2_q && m_ready;

  always_comb begin
    v1_d        = v1_q;
    sum1_d      = sum1_q;
    last1_d     = last1_q;
    relu1_d     = relu1_q;
    v2_d        = v2_q;
    data2_d     = data2_q;
    last2_d     = last2_q;
    frameDone_d = outFire && last2_q;
    satCnt_d    = satCnt_q;

    if (inFire) begin
      v1_d    = 1'b1;
      sum1_d  = sumNow;
      last1_d = s_last;
      relu1_d = relu_en;
    end else if (advance2) begin
      v1_d = 1'b0;
    end

    // Stage 2 refills from stage 1 whenever it empties or is drained this cycle.
    if (advance2) begin
      v2_d    = 1'b1;
      data2_d = laneRes;
      last2_d = last1_q;
      if ((|laneSat) && (satCnt_q != '1)) satCnt_d = satCnt_q + 1'b1;
    end else if (outFire) begin
      v2_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      sum1_q      <= '0;
      last1_q     <= 1'b0;
      relu1_q     <= 1'b0;
      v2_q        <= 1'b0;
      data2_q     <= '0;
      last2_q     <= 1'b0;
      frameDone_q <= 1'b0;
      satCnt_q    <= '0;
    end else begin
      v1_q        <= v1_d;
      sum1_q      <= sum1_d;
      last1_q     <= last1_d;
      relu1_q     <= relu1_d;
      v2_q        <= v2_d;
      data2_q     <= data2_d;
      last2_q     <= last2_d;
      frameDone_q <= frameDone_d;
      satCnt_q    <= satCnt_d;
    end
  end

  assign m_valid    = v2_q;
  assign m_data     = data2_q;
  assign m_last     = last2_q;
  assign frame_done = frameDone_q;
  assign sat_cnt    = satCnt_q;

endmodule

// File: tb/tb_bias_add_sat_stage.sv
// Directed bench for bias_add_sat_stage: single-beat vector table plus stall,
// framing and mid-stream reset sequences, all checked against hand-computed values.
module tb_bias_add_sat_stage;
  import bias_add_sat_stage_pkg::*;

  localparam int N  = N_LANES;
  localparam int WL = LANE_W;
  localparam int BW = N * WL;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] bias_in;
  logic          relu_en;
  logic          s_valid;
  logic          s_ready;
  logic [BW-1:0] s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [BW-1:0] m_data;
  logic          m_last;
  logic          frame_done;
  logic [15:0]   sat_cnt;

  int total = 0;
  int bad   = 0;
  int expSat = 0;

  always #5 clk = ~clk;

  bias_add_sat_stage #(.N_adder_tree(N), .W(WL), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bias_in    (bias_in),
    .relu_en    (relu_en),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .frame_done (frame_done),
    .sat_cnt    (sat_cnt)
  );

  typedef struct {
    string        name;
    int           lane;
    logic [WL-1:0] data;
    logic [WL-1:0] bias;
    logic         relu;
    logic [WL-1:0] expLane;
    int           satInc;
  } vecT;

  vecT vecs[11];

  task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] placeLane(input int k, input logic [WL-1:0] v);
    logic [BW-1:0] r;
    r = '0;
    r[k*WL +: WL] = v;
    return r;
  endfunction

  function automatic logic [BW-1:0] beatData(input int j);
    return placeLane(0, WL'(j + 1)) | placeLane(15, WL'(32'h100 + j));
  endfunction

  function automatic logic [BW-1:0] beatExp(input int j);
    return placeLane(0, WL'(j + 1 + 32'h10)) | placeLane(15, WL'(32'h100 + j));
  endfunction

  // One isolated beat with m_ready high: result must appear exactly two cycles later.
  task automatic applyStimulus(input vecT v);
    @(posedge clk); #1;
    s_data  = placeLane(v.lane, v.data);
    bias_in = placeLane(v.lane, v.bias);
    relu_en = v.relu;
    s_last  = 1'b0;
    m_ready = 1'b1;
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_data  = '1;
    bias_in = '1;
    relu_en = ~v.relu;
    @(negedge clk);
    checkOutput({v.name, " early m_valid"}, BW'(m_valid), BW'(1'b0));
    @(posedge clk);
    @(negedge clk);
    expSat += v.satInc;
    checkOutput({v.name, " m_valid"}, BW'(m_valid), BW'(1'b1));
    checkOutput({v.name, " m_data"}, m_data, placeLane(v.lane, v.expLane));
    checkOutput({v.name, " sat_cnt"}, BW'(sat_cnt), BW'(expSat));
    checkOutput({v.name, " frame_done"}, BW'(frame_done), BW'(1'b0));
  endtask

  // Streams nBeats back-to-back; m_ready is low for cycles stallLo..stallHi.
  task automatic runStream(input int nBeats, input int stallLo, input int stallHi,
                           input int lastIdx, input string tag);
    int inIdx = 0;
    int outIdx = 0;
    int cyc = 0;
    bit prevStall = 0;
    bit prevLastHs = 0;
    bit sawFull = 0;
    logic [BW-1:0] prevData = '0;
    bias_in = placeLane(0, 18'h00010);
    relu_en = 1'b0;
    @(posedge clk); #1;
    m_ready = !(cyc >= stallLo && cyc <= stallHi);
    s_valid = 1'b1;
    s_data  = beatData(0);
    s_last  = (lastIdx == 0);
    while (outIdx < nBeats && cyc < 200) begin
      @(negedge clk);
      checkOutput({tag, " frame_done"}, BW'(frame_done), BW'(prevLastHs));
      if (prevStall) begin
        checkOutput({tag, " hold m_valid"}, BW'(m_valid), BW'(1'b1));
        checkOutput({tag, " hold m_data"}, m_data, prevData);
      end
      checkOutput({tag, " s_ready"}, BW'(s_ready), BW'(((inIdx - outIdx) < 2) || m_ready));
      if (!s_ready) sawFull = 1;
      prevLastHs = 0;
      if (m_valid && m_ready) begin
        checkOutput({tag, " m_data"}, m_data, beatExp(outIdx));
        checkOutput({tag, " m_last"}, BW'(m_last), BW'(outIdx == lastIdx));
        prevLastHs = (outIdx == lastIdx);
        outIdx++;
      end
      prevStall = m_valid && !m_ready;
      prevData  = m_data;
      if (s_valid && s_ready) inIdx++;
      @(posedge clk); #1;
      cyc++;
      m_ready = !(cyc >= stallLo && cyc <= stallHi);
      s_valid = (inIdx < nBeats);
      s_data  = (inIdx < nBeats) ? beatData(inIdx) : '0;
      s_last  = (inIdx == lastIdx);
    end
    if (outIdx < nBeats) checkOutput({tag, " beats delivered"}, BW'(outIdx), BW'(nBeats));
    @(negedge clk);
    checkOutput({tag, " frame_done tail"}, BW'(frame_done), BW'(prevLastHs));
    if (stallLo >= 0) checkOutput({tag, " s_ready dropped"}, BW'(sawFull), BW'(1'b1));
  endtask

  initial begin
    vecs[0]  = '{"add",      0, 18'h00100, 18'h00ABC, 1'b0, 18'h00BBC, 0};
    vecs[1]  = '{"posSat",   3, 18'h1FF00, 18'h00200, 1'b0, 18'h1FFFF, 1};
    vecs[2]  = '{"negSat",   3, 18'h20010, 18'h3FFE0, 1'b0, 18'h20000, 1};
    vecs[3]  = '{"reluNeg",  8, 18'h3FF00, 18'h3EB5C, 1'b1, 18'h00000, 0};
    vecs[4]  = '{"noRelu",   8, 18'h3FF00, 18'h3EB5C, 1'b0, 18'h3EA5C, 0};
    vecs[5]  = '{"reluSat",  5, 18'h20000, 18'h20000, 1'b1, 18'h00000, 1};
    vecs[6]  = '{"edgeMax", 15, 18'h1FFFF, 18'h00000, 1'b0, SAT_MAX,   0};
    vecs[7]  = '{"edgeMin", 15, 18'h20000, 18'h00000, 1'b0, SAT_MIN,   0};
    vecs[8]  = '{"justOver", 7, 18'h1FFFF, 18'h00001, 1'b0, 18'h1FFFF, 1};
    vecs[9]  = '{"reluPos",  2, 18'h12345, 18'h01111, 1'b1, 18'h13456, 0};
    vecs[10] = '{"zeroSum",  1, 18'h00001, 18'h3FFFF, 1'b1, 18'h00000, 0};

    rst = 1'b1;
    bias_in = '0;
    relu_en = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset m_valid", BW'(m_valid), BW'(1'b0));
    checkOutput("reset m_data", m_data, '0);
    checkOutput("reset m_last", BW'(m_last), BW'(1'b0));
    checkOutput("reset frame_done", BW'(frame_done), BW'(1'b0));
    checkOutput("reset sat_cnt", BW'(sat_cnt), BW'(0));
    checkOutput("reset s_ready", BW'(s_ready), BW'(1'b1));

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

    runStream(10, 3, 7, -1, "stall");
    checkOutput("stall sat_cnt", BW'(sat_cnt), BW'(expSat));
    runStream(4, -1, -1, 3, "frame");

    // Two saturating beats parked in the pipeline, then a reset wipes them.
    @(posedge clk); #1;
    m_ready = 1'b0;
    relu_en = 1'b0;
    s_last  = 1'b0;
    s_data  = placeLane(3, 18'h1FF00);
    bias_in = placeLane(3, 18'h00200);
    s_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    checkOutput("full s_ready", BW'(s_ready), BW'(1'b0));
    checkOutput("full sat_cnt", BW'(sat_cnt), BW'(expSat + 1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    s_data  = placeLane(0, 18'h00100);
    bias_in = placeLane(0, 18'h00ABC);
    s_valid = 1'b1;
    @(negedge clk);
    checkOutput("rst m_valid", BW'(m_valid), BW'(1'b0));
    checkOutput("rst sat_cnt", BW'(sat_cnt), BW'(0));
    checkOutput("rst s_ready", BW'(s_ready), BW'(1'b1));
    checkOutput("rst m_data", m_data, '0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    checkOutput("post-rst early m_valid", BW'(m_valid), BW'(1'b0));
    @(posedge clk);
    @(negedge clk);
    checkOutput("post-rst m_valid", BW'(m_valid), BW'(1'b1));
    checkOutput("post-rst m_data", m_data, placeLane(0, 18'h00BBC));
    checkOutput("post-rst lane helper", BW'(laneSlice(m_data, 0)), BW'(18'h00BBC));
    checkOutput("post-rst sat_cnt", BW'(sat_cnt), BW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
